// File: rtl/pll_dynphase_pkg.sv
// rtl/pll_dynphase_pkg.sv - shared types and constants for the dynamic phase responder
package pll_dynphase_pkg;

  localparam int NUM_CLK   = 6;
  localparam int PHCNTRWID = 3;
  localparam int PHASE_W   = NUM_CLK * PHCNTRWID;

  // Output select indices as seen on phasesel_i
  localparam logic [2:0] IDX_CLKOP  = 3'd0;
  localparam logic [2:0] IDX_CLKOS  = 3'd1;
  localparam logic [2:0] IDX_CLKOS2 = 3'd2;
  localparam logic [2:0] IDX_CLKOS3 = 3'd3;
  localparam logic [2:0] IDX_CLKOS4 = 3'd4;
  localparam logic [2:0] IDX_CLKOS5 = 3'd5;
  // Highest valid select; 6 and 7 address no output
  localparam logic [2:0] IDX_CLKS5  = IDX_CLKOS5;

  typedef enum logic [1:0] {
    ST_LOCKWAIT = 2'd0,
    ST_IDLE     = 2'd1,
    ST_STEP     = 2'd2,
    ST_LOAD     = 2'd3
  } state_e;

  function automatic logic sel_valid(input logic [2:0] sel);
    return (sel <= IDX_CLKS5);
  endfunction

endpackage

// File: rtl/pll_dynphase_responder_if.sv
// rtl/pll_dynphase_responder_if.sv - phase control bus between a controller and the responder
interface pll_dynphase_responder_if;
  import pll_dynphase_pkg::*;

  logic               phasedir_i;
  logic               phasestep_i;
  logic               phaseloadreg_i;
  logic [2:0]         phasesel_i;
  logic [PHASE_W-1:0] phase_o;
  logic               busy_o;
  logic               pll_lock_o;
  logic               err_o;

  modport master (
    output phasedir_i, phasestep_i, phaseloadreg_i, phasesel_i,
    input  phase_o, busy_o, pll_lock_o, err_o
  );

  modport slave (
    input  phasedir_i, phasestep_i, phaseloadreg_i, phasesel_i,
    output phase_o, busy_o, pll_lock_o, err_o
  );
endinterface

// File: rtl/pll_dynphase_edge_det.sv
// rtl/pll_dynphase_edge_det.sv - single-register rising-edge detector
module pll_dynphase_edge_det (
  input  logic clk_i,
  input  logic rst_i,
  input  logic sig_i,
  output logic rise_o
);

  logic sig_q;

  // Remember last cycle's level so a held-high request counts only once
  always_ff @(posedge clk_i) begin
    if (rst_i) sig_q <= 1'b0;
    else       sig_q <= sig_i;
  end

  assign rise_o = sig_i & ~sig_q;

endmodule

// File: rtl/pll_dynphase_responder.sv
// rtl/pll_dynphase_responder.sv - emulated PLL dynamic phase shift responder (checker: PLL_DYNPHASE_CHK_EN)
module pll_dynphase_responder
  import pll_dynphase_pkg::*;
#(
  parameter int                 LOCK_CYCLES = 64,
  parameter int                 STEP_LAT    = 2,
  parameter logic [PHASE_W-1:0] PHI_INIT    = 18'h0
) (
  input logic                     clk_i,
  input logic                     rst_i,
  pll_dynphase_responder_if.slave bus
);

  localparam logic [9:0] LOCK_LAST = 10'(LOCK_CYCLES - 1);
  localparam logic [3:0] STEP_LAST = 4'(STEP_LAT - 1);

  state_e             state_q, state_d;
  logic [9:0]         lock_cnt_q, lock_cnt_d;
  logic [3:0]         step_cnt_q, step_cnt_d;
  logic [2:0]         sel_q, sel_d;
  logic               dir_q, dir_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic               lock_q, lock_d;
  logic               step_rise;
  logic               load_rise;

  pll_dynphase_edge_det u_step_edge (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .sig_i  (bus.phasestep_i),
    .rise_o (step_rise)
  );

  pll_dynphase_edge_det u_load_edge (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .sig_i  (bus.phaseloadreg_i),
    .rise_o (load_rise)
  );

  // State and datapath registers; reset discards any pending step or load
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_LOCKWAIT;
      lock_cnt_q <= '0;
      step_cnt_q <= '0;
      sel_q      <= '0;
      dir_q      <= 1'b0;
      phase_q    <= PHI_INIT;
      lock_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      lock_cnt_q <= lock_cnt_d;
      step_cnt_q <= step_cnt_d;
      sel_q      <= sel_d;
      dir_q      <= dir_d;
      phase_q    <= phase_d;
      lock_q     <= lock_d;
    end
  end

  // Next-state: lock wait, request acceptance, delayed step and one-cycle reload
  always_comb begin
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    step_cnt_d = step_cnt_q;
    sel_d      = sel_q;
    dir_d      = dir_q;
    phase_d    = phase_q;
    lock_d     = lock_q;
    case (state_q)
      ST_LOCKWAIT: begin
        if (lock_cnt_q == LOCK_LAST) begin
          lock_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          lock_cnt_d = lock_cnt_q + 10'd1;
        end
      end
      ST_IDLE: begin
        // Reload takes priority when both edges arrive together
        if (load_rise && sel_valid(bus.phasesel_i)) begin
          sel_d   = bus.phasesel_i;
          state_d = ST_LOAD;
        end else if (step_rise && sel_valid(bus.phasesel_i)) begin
          sel_d      = bus.phasesel_i;
          dir_d      = bus.phasedir_i;
          step_cnt_d = STEP_LAST;
          state_d    = ST_STEP;
        end
      end
      ST_STEP: begin
        if (step_cnt_q == 4'd0) begin
          for (int n = 0; n < NUM_CLK; n++) begin
            if (sel_q == 3'(n)) begin
              phase_d[n*PHCNTRWID +: PHCNTRWID] = dir_q
                ? phase_q[n*PHCNTRWID +: PHCNTRWID] - 3'd1
                : phase_q[n*PHCNTRWID +: PHCNTRWID] + 3'd1;
            end
          end
          state_d = ST_IDLE;
        end else begin
          step_cnt_d = step_cnt_q - 4'd1;
        end
      end
      ST_LOAD: begin
        for (int n = 0; n < NUM_CLK; n++) begin
          if (sel_q == 3'(n)) begin
            phase_d[n*PHCNTRWID +: PHCNTRWID] = PHI_INIT[n*PHCNTRWID +: PHCNTRWID];
          end
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_LOCKWAIT;
    endcase
  end

  assign bus.phase_o    = phase_q;
  assign bus.busy_o     = (state_q == ST_STEP) || (state_q == ST_LOAD);
  assign bus.pll_lock_o = lock_q;

`ifdef PLL_DYNPHASE_CHK_EN
  logic err_q, err_d;

  // Flag dropped requests and select changes during an operation
  always_comb begin
    err_d = err_q;
    case (state_q)
      ST_IDLE: begin
        if ((step_rise || load_rise) && !sel_valid(bus.phasesel_i)) err_d = 1'b1;
        if (step_rise && load_rise) err_d = 1'b1;
      end
      ST_STEP, ST_LOAD: begin
        if (step_rise || load_rise) err_d = 1'b1;
        if (bus.phasesel_i != sel_q) err_d = 1'b1;
      end
      default: ;
    endcase
  end

  // Sticky error flag, cleared only by reset
  always_ff @(posedge clk_i) begin
    if (rst_i) err_q <= 1'b0;
    else       err_q <= err_d;
  end

  assign bus.err_o = err_q;
`else
  assign bus.err_o = 1'b0;
`endif

endmodule

// File: tb/tb_pll_dynphase_responder.sv
// tb/tb_pll_dynphase_responder.sv - directed self-checking bench for pll_dynphase_responder
module tb_pll_dynphase_responder;
  import pll_dynphase_pkg::*;

  localparam logic [17:0] PHI = {3'd4, 3'd2, 3'd1, 3'd6, 3'd5, 3'd3};
`ifdef PLL_DYNPHASE_CHK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       step = 1'b0;
  logic       load = 1'b0;
  logic       dir = 1'b0;
  logic [2:0] sel = 3'd0;
  int         vecs = 0;
  int         errs = 0;
  logic [17:0] exp_a;

  always #5 clk = ~clk;

  pll_dynphase_responder_if if_a ();
  pll_dynphase_responder_if if_b ();

  assign if_a.phasestep_i    = step;
  assign if_a.phaseloadreg_i = load;
  assign if_a.phasedir_i     = dir;
  assign if_a.phasesel_i     = sel;
  assign if_b.phasestep_i    = step;
  assign if_b.phaseloadreg_i = load;
  assign if_b.phasedir_i     = dir;
  assign if_b.phasesel_i     = sel;

  pll_dynphase_responder #(.LOCK_CYCLES(64), .STEP_LAT(2), .PHI_INIT(PHI)) dut_a (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (if_a.slave)
  );

  pll_dynphase_responder #(.LOCK_CYCLES(64), .STEP_LAT(4), .PHI_INIT(PHI)) dut_b (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (if_b.slave)
  );

  function automatic logic [2:0] fld(input logic [17:0] p, input int n);
    return p[n*3 +: 3];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    int waited;
    rst = 1'b1; step = 1'b0; load = 1'b0;
    tick(); tick();
    rst = 1'b0;
    waited = 0;
    while (!if_a.pll_lock_o && waited < 80) begin
      tick();
      waited++;
    end
    vecs++;
    if (if_a.pll_lock_o !== 1'b1) begin
      errs++;
      $display("FAIL reset_lock_wait: lock=%b required 1 within 80 cycles", if_a.pll_lock_o);
    end
    exp_a = PHI;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    vecs++; if (if_a.phase_o !== PHI) begin errs++; $display("FAIL reset_phase: got %h required %h", if_a.phase_o, PHI); end
    vecs++; if (if_a.busy_o !== 1'b0) begin errs++; $display("FAIL reset_busy: got %b required 0", if_a.busy_o); end
    vecs++; if (if_a.pll_lock_o !== 1'b0) begin errs++; $display("FAIL reset_lock: got %b required 0", if_a.pll_lock_o); end
    vecs++; if (if_a.err_o !== 1'b0) begin errs++; $display("FAIL reset_err: got %b required 0", if_a.err_o); end
    rst = 1'b0;
    repeat (63) tick();
    vecs++; if (if_a.pll_lock_o !== 1'b0) begin errs++; $display("FAIL lock_early_a: got %b required 0 at cycle 63", if_a.pll_lock_o); end
    vecs++; if (if_b.pll_lock_o !== 1'b0) begin errs++; $display("FAIL lock_early_b: got %b required 0 at cycle 63", if_b.pll_lock_o); end
    tick();
    vecs++; if (if_a.pll_lock_o !== 1'b1) begin errs++; $display("FAIL lock_rise_a: got %b required 1 at cycle 64", if_a.pll_lock_o); end
    vecs++; if (if_a.phase_o !== PHI) begin errs++; $display("FAIL lock_phase: got %h required %h", if_a.phase_o, PHI); end
    exp_a = PHI;
  endtask

  task automatic test_step_inc();
    logic [2:0] seq [3];
    seq[0] = 3'd7; seq[1] = 3'd0; seq[2] = 3'd1;
    sel = 3'd2; dir = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step = 1'b1;
      tick();
      step = 1'b0;
      vecs++; if (if_a.busy_o !== 1'b1) begin errs++; $display("FAIL inc_busy[%0d]: got %b required 1", k, if_a.busy_o); end
      tick();
      vecs++; if (if_a.phase_o !== exp_a) begin errs++; $display("FAIL inc_early[%0d]: got %h required %h", k, if_a.phase_o, exp_a); end
      tick();
      exp_a[6 +: 3] = seq[k];
      vecs++; if (if_a.phase_o !== exp_a) begin errs++; $display("FAIL inc_update[%0d]: got %h required %h", k, if_a.phase_o, exp_a); end
      vecs++; if (if_a.busy_o !== 1'b0) begin errs++; $display("FAIL inc_idle[%0d]: got %b required 0", k, if_a.busy_o); end
      tick();
    end
  endtask

  task automatic test_dec_reload();
    logic [2:0] seq [4];
    seq[0] = 3'd2; seq[1] = 3'd1; seq[2] = 3'd0; seq[3] = 3'd7;
    sel = 3'd0; dir = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step = 1'b1;
      tick();
      step = 1'b0;
      tick(); tick();
      exp_a[0 +: 3] = seq[k];
      vecs++; if (fld(if_a.phase_o, 0) !== seq[k]) begin errs++; $display("FAIL dec[%0d]: got %0d required %0d", k, fld(if_a.phase_o, 0), seq[k]); end
      tick();
    end
    load = 1'b1;
    tick();
    load = 1'b0;
    vecs++; if (if_a.busy_o !== 1'b1) begin errs++; $display("FAIL reload_busy: got %b required 1", if_a.busy_o); end
    tick();
    exp_a[0 +: 3] = 3'd3;
    vecs++; if (if_a.phase_o !== exp_a) begin errs++; $display("FAIL reload_phase: got %h required %h", if_a.phase_o, exp_a); end
    vecs++; if (if_a.busy_o !== 1'b0) begin errs++; $display("FAIL reload_idle: got %b required 0", if_a.busy_o); end
    tick();
  endtask

  task automatic test_invalid_sel();
    sel = 3'd7; dir = 1'b0;
    step = 1'b1;
    tick();
    step = 1'b0;
    vecs++; if (if_a.busy_o !== 1'b0) begin errs++; $display("FAIL inv_step_busy: got %b required 0", if_a.busy_o); end
    repeat (3) tick();
    vecs++; if (if_a.phase_o !== exp_a) begin errs++; $display("FAIL inv_step_phase: got %h required %h", if_a.phase_o, exp_a); end
    sel = 3'd6;
    load = 1'b1;
    tick();
    load = 1'b0;
    vecs++; if (if_a.busy_o !== 1'b0) begin errs++; $display("FAIL inv_load_busy: got %b required 0", if_a.busy_o); end
    tick();
    vecs++; if (if_a.phase_o !== exp_a) begin errs++; $display("FAIL inv_load_phase: got %h required %h", if_a.phase_o, exp_a); end
  endtask

  task automatic test_overrun();
    do_reset();
    vecs++; if (if_b.err_o !== 1'b0) begin errs++; $display("FAIL ovr_err_pre: got %b required 0", if_b.err_o); end
    sel = 3'd3; dir = 1'b0;
    step = 1'b1; tick();
    step = 1'b0; tick();
    step = 1'b1; tick();
    step = 1'b0; tick();
    vecs++; if (fld(if_b.phase_o, 3) !== 3'd1) begin errs++; $display("FAIL ovr_early: got %0d required 1", fld(if_b.phase_o, 3)); end
    tick();
    vecs++; if (fld(if_b.phase_o, 3) !== 3'd2) begin errs++; $display("FAIL ovr_update: got %0d required 2", fld(if_b.phase_o, 3)); end
    repeat (6) tick();
    vecs++; if (fld(if_b.phase_o, 3) !== 3'd2) begin errs++; $display("FAIL ovr_single: got %0d required 2", fld(if_b.phase_o, 3)); end
    vecs++; if (if_b.err_o !== EXP_ERR) begin errs++; $display("FAIL ovr_err: got %b required %b", if_b.err_o, EXP_ERR); end
  endtask

  task automatic test_step_reload_same();
    do_reset();
    sel = 3'd1; dir = 1'b0;
    step = 1'b1; tick();
    step = 1'b0; tick(); tick();
    vecs++; if (fld(if_a.phase_o, 1) !== 3'd6) begin errs++; $display("FAIL both_prestep: got %0d required 6", fld(if_a.phase_o, 1)); end
    tick();
    vecs++; if (if_a.err_o !== 1'b0) begin errs++; $display("FAIL both_err_pre: got %b required 0", if_a.err_o); end
    step = 1'b1; load = 1'b1;
    tick();
    step = 1'b0; load = 1'b0;
    vecs++; if (if_a.busy_o !== 1'b1) begin errs++; $display("FAIL both_busy: got %b required 1", if_a.busy_o); end
    tick();
    vecs++; if (if_a.phase_o !== PHI) begin errs++; $display("FAIL both_phase: got %h required %h", if_a.phase_o, PHI); end
    vecs++; if (if_a.busy_o !== 1'b0) begin errs++; $display("FAIL both_idle: got %b required 0", if_a.busy_o); end
    repeat (3) tick();
    vecs++; if (if_a.phase_o !== PHI) begin errs++; $display("FAIL both_no_step: got %h required %h", if_a.phase_o, PHI); end
    vecs++; if (if_a.err_o !== EXP_ERR) begin errs++; $display("FAIL both_err: got %b required %b", if_a.err_o, EXP_ERR); end
  endtask

  task automatic test_reset_mid_step();
    sel = 3'd5; dir = 1'b0;
    step = 1'b1; tick();
    step = 1'b0; tick(); tick();
    vecs++; if (fld(if_a.phase_o, 5) !== 3'd5) begin errs++; $display("FAIL mid_prestep: got %0d required 5", fld(if_a.phase_o, 5)); end
    tick();
    sel = 3'd4;
    step = 1'b1; tick();
    step = 1'b0;
    vecs++; if (if_a.busy_o !== 1'b1) begin errs++; $display("FAIL mid_busy: got %b required 1", if_a.busy_o); end
    rst = 1'b1;
    tick();
    vecs++; if (if_a.phase_o !== PHI) begin errs++; $display("FAIL mid_phase: got %h required %h", if_a.phase_o, PHI); end
    vecs++; if (if_a.pll_lock_o !== 1'b0) begin errs++; $display("FAIL mid_lock: got %b required 0", if_a.pll_lock_o); end
    vecs++; if (if_a.busy_o !== 1'b0) begin errs++; $display("FAIL mid_busy_clr: got %b required 0", if_a.busy_o); end
    rst = 1'b0;
    repeat (4) tick();
    vecs++; if (if_a.phase_o !== PHI) begin errs++; $display("FAIL mid_no_late: got %h required %h", if_a.phase_o, PHI); end
  endtask

  initial begin
    exp_a = PHI;
    test_reset();
    test_step_inc();
    test_dec_reload();
    test_invalid_sel();
    test_overrun();
    test_step_reload_same();
    test_reset_mid_step();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
